mcu_emulator: RTL and testbench

MCU_EMULATOR -- requirements
Module: mcu_emulator

---
 rtl/mcu_dbg_pkg.sv | 26 ++
 rtl/mcu_emu_mem.sv | 30 +++
 rtl/mcu_emulator.sv | 147 ++++++++++++++
 tb/tb_mcu_emulator.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mcu_dbg_pkg.sv
// rtl/mcu_dbg_pkg.sv - command codes and core states shared by the MCU emulator
package mcu_dbg_pkg;

    typedef enum logic [2:0] {
        CMD_NONE   = 3'd0,
        CMD_PAUSE  = 3'd1,
        CMD_RESUME = 3'd2,
        CMD_REG_RD = 3'd3,
        CMD_REG_WR = 3'd4,
        CMD_MEM_RD = 3'd5,
        CMD_MEM_WR = 3'd6,
        CMD_RESET  = 3'd7
    } cmd_e;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_HALT      = 2'd1,
        ST_BUSY_RUN  = 2'd2,
        ST_BUSY_HALT = 2'd3
    } state_e;

    function automatic logic is_data_cmd(input cmd_e c);
        return (c == CMD_REG_RD) || (c == CMD_REG_WR) || (c == CMD_MEM_RD) || (c == CMD_MEM_WR);
    endfunction

endpackage

// File: rtl/mcu_emu_mem.sv
// rtl/mcu_emu_mem.sv - emulated 32-bit memory with byte-lane write enables
module mcu_emu_mem
    import mcu_dbg_pkg::*;
#(
    parameter int WORDS = 256,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= '0;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mcu_emulator.sv
// rtl/mcu_emulator.sv - debug-port model of an MCU core: run/halt, pc, register file and memory access
module mcu_emulator
    import mcu_dbg_pkg::*;
#(
    parameter int BUSY_CYCLES = 16,
    parameter int REG_DEPTH   = 32,
    parameter int MEM_WORDS   = 256,
    parameter int PC_STEP     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] d_in,
    input  logic        pause,
    input  logic        resume,
    input  logic        reset,
    input  logic        reg_rd,
    input  logic        reg_wr,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic        mem_rw_byte,
    input  logic        valid,
    output logic        mcu_busy,
    output logic [31:0] pc,
    output logic [31:0] d_rd,
    output logic        paused,
    output logic [2:0]  last_cmd,
    output logic        cmd_err
);

    localparam int RAW = $clog2(REG_DEPTH);
    localparam int MAW = $clog2(MEM_WORDS);
    localparam int CW  = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES) : 1;
    localparam logic [31:0] PC_MASK = 32'(MEM_WORDS * 4 - 1);
    localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q;
    cmd_e           cmd, last_q;
    logic           any_strobe, accept, drop, legal, mem_oor, err_d;
    logic           reg_we, rd_pend_q, busy_done, dest_halt;
    logic [RAW-1:0] reg_idx;
    logic [3:0]     mem_we;
    logic [31:0]    mem_wdata, mem_rdata, rd_val, rd_data_q;
    logic [31:0]    regs [REG_DEPTH];

    assign mcu_busy  = (state_q == ST_BUSY_RUN) || (state_q == ST_BUSY_HALT);
    assign paused    = (state_q == ST_HALT) || (state_q == ST_BUSY_HALT);
    assign last_cmd  = last_q;
    assign busy_done = mcu_busy && (cnt_q == '0);
    assign reg_idx   = addr[RAW-1:0];
    assign mem_oor   = (addr >= MEM_BYTES);

    always_comb begin
        cmd = CMD_NONE;
        if      (pause)  cmd = CMD_PAUSE;
        else if (resume) cmd = CMD_RESUME;
        else if (reset)  cmd = CMD_RESET;
        else if (reg_rd) cmd = CMD_REG_RD;
        else if (reg_wr) cmd = CMD_REG_WR;
        else if (mem_rd) cmd = CMD_MEM_RD;
        else if (mem_wr) cmd = CMD_MEM_WR;
    end

    assign any_strobe = pause | resume | reset | reg_rd | reg_wr | mem_rd | mem_wr;
    assign accept     = valid && any_strobe && !mcu_busy;
    assign drop       = valid && any_strobe && mcu_busy;
    // Data ops run their busy period even when refused, so "legal" only gates side effects.
    assign legal      = accept && is_data_cmd(cmd) && paused;
    assign err_d      = drop
                      || (accept && is_data_cmd(cmd) && !paused)
                      || (legal && (cmd == CMD_MEM_RD || cmd == CMD_MEM_WR) && mem_oor);

    assign reg_we    = legal && (cmd == CMD_REG_WR) && (reg_idx != '0);
    assign mem_we    = (legal && (cmd == CMD_MEM_WR) && !mem_oor)
                     ? (mem_rw_byte ? (4'b0001 << addr[1:0]) : 4'b1111) : 4'b0000;
    assign mem_wdata = mem_rw_byte ? {4{d_in[7:0]}} : d_in;

    always_comb begin
        rd_val = '0;
        if (cmd == CMD_REG_RD && reg_idx != '0) begin
            rd_val = regs[reg_idx];
        end else if (cmd == CMD_MEM_RD && !mem_oor) begin
            rd_val = mem_rw_byte ? {24'b0, mem_rdata[{addr[1:0], 3'b000} +: 8]} : mem_rdata;
        end
    end

    assign dest_halt = (cmd == CMD_PAUSE) || (paused && cmd != CMD_RESUME && cmd != CMD_RESET);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN, ST_HALT: if (accept) state_d = dest_halt ? ST_BUSY_HALT : ST_BUSY_RUN;
            ST_BUSY_RUN:     if (busy_done) state_d = ST_RUN;
            ST_BUSY_HALT:    if (busy_done) state_d = ST_HALT;
            default:         state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            cnt_q     <= '0;
            pc        <= '0;
            d_rd      <= '0;
            last_q    <= CMD_NONE;
            cmd_err   <= 1'b0;
            rd_pend_q <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q <= state_d;
            cmd_err <= err_d;
            if (accept) begin
                cnt_q     <= CW'(BUSY_CYCLES - 1);
                last_q    <= cmd;
                rd_pend_q <= legal && (cmd == CMD_REG_RD || cmd == CMD_MEM_RD);
                rd_data_q <= rd_val;
            end else if (mcu_busy && !busy_done) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (busy_done && rd_pend_q) begin
                d_rd      <= rd_data_q;
                rd_pend_q <= 1'b0;
            end
            if (accept && cmd == CMD_RESET) pc <= '0;
            else if (!paused)                pc <= (pc + 32'(PC_STEP)) & PC_MASK;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_DEPTH; i++) regs[i] <= '0;
        end else if (reg_we) begin
            regs[reg_idx] <= d_in;
        end
    end

    mcu_emu_mem #(.WORDS(MEM_WORDS)) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .addr  (addr[MAW+1:2]),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_mcu_emulator.sv
// tb/tb_mcu_emulator.sv - directed self-checking bench for mcu_emulator
module tb_mcu_emulator;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr, d_in;
    logic        pause, resume, reset, reg_rd, reg_wr, mem_rd, mem_wr;
    logic        mem_rw_byte, valid;
    logic        mcu_busy, paused, cmd_err;
    logic [31:0] pc, d_rd;
    logic [2:0]  last_cmd;

    int vec_cnt = 0;
    int err_cnt = 0;
    int busy_len;
    logic        err_seen, paused_first;
    logic [31:0] pc_first;

    localparam logic [6:0] S_PAUSE  = 7'b1000000;
    localparam logic [6:0] S_RESUME = 7'b0100000;
    localparam logic [6:0] S_RESET  = 7'b0010000;
    localparam logic [6:0] S_RRD    = 7'b0001000;
    localparam logic [6:0] S_RWR    = 7'b0000100;
    localparam logic [6:0] S_MRD    = 7'b0000010;
    localparam logic [6:0] S_MWR    = 7'b0000001;

    mcu_emulator dut (
        .clk(clk), .rst(rst), .addr(addr), .d_in(d_in),
        .pause(pause), .resume(resume), .reset(reset),
        .reg_rd(reg_rd), .reg_wr(reg_wr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_rw_byte(mem_rw_byte), .valid(valid),
        .mcu_busy(mcu_busy), .pc(pc), .d_rd(d_rd), .paused(paused),
        .last_cmd(last_cmd), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [6:0] s, input logic [31:0] a, input logic [31:0] d, input logic b);
        {pause, resume, reset, reg_rd, reg_wr, mem_rd, mem_wr} = s;
        addr = a; d_in = d; mem_rw_byte = b;
        valid = (s != 7'b0);
    endtask

    task automatic wait_idle();
        busy_len = 0;
        while (mcu_busy && busy_len < 100) begin
            busy_len++;
            @(negedge clk);
        end
        if (busy_len >= 100) check_vec("busy_timeout", 32'(busy_len), 32'd16);
    endtask

    // Issue one command at a negedge, then run out its busy period.
    task automatic send(input logic [6:0] s, input logic [31:0] a, input logic [31:0] d, input logic b);
        drive(s, a, d, b);
        @(negedge clk);
        drive(7'b0, 32'h0, 32'h0, 1'b0);
        err_seen = cmd_err; pc_first = pc; paused_first = paused;
        wait_idle();
    endtask

    initial begin
        rst = 1'b1;
        drive(7'b0, 32'h0, 32'h0, 1'b0);
        repeat (2) @(negedge clk);
        check_vec("rst_pc", pc, 32'd0);
        check_vec("rst_d_rd", d_rd, 32'd0);
        check_vec("rst_last_cmd", 32'(last_cmd), 32'd0);
        check_vec("rst_busy", 32'(mcu_busy), 32'd0);
        check_vec("rst_paused", 32'(paused), 32'd0);
        check_vec("rst_cmd_err", 32'(cmd_err), 32'd0);
        rst = 1'b0;

        repeat (10) @(negedge clk);
        check_vec("idle_pc", pc, 32'd40);
        check_vec("idle_paused", 32'(paused), 32'd0);
        check_vec("idle_busy", 32'(mcu_busy), 32'd0);

        send(S_PAUSE, 32'h0, 32'h0, 1'b0);
        check_vec("pause_busy_len", 32'(busy_len), 32'd16);
        check_vec("pause_paused", 32'(paused), 32'd1);
        check_vec("pause_last_cmd", 32'(last_cmd), 32'd1);
        check_vec("pause_pc_first", pc_first, 32'd44);
        check_vec("pause_pc_frozen", pc, 32'd44);
        check_vec("pause_err", 32'(err_seen), 32'd0);

        send(S_RWR, 32'd5, 32'hCAFEF00D, 1'b0);
        check_vec("regwr_last_cmd", 32'(last_cmd), 32'd4);
        send(S_RWR, 32'd9, 32'h12345678, 1'b0);
        send(S_RRD, 32'd5, 32'h0, 1'b0);
        check_vec("regrd5", d_rd, 32'hCAFEF00D);
        check_vec("regrd_last_cmd", 32'(last_cmd), 32'd3);
        send(S_RWR, 32'd0, 32'hFFFFFFFF, 1'b0);
        send(S_RRD, 32'd0, 32'h0, 1'b0);
        check_vec("regrd0", d_rd, 32'h0);
        send(S_RRD, 32'h25, 32'h0, 1'b0);
        check_vec("regrd_hi_bits", d_rd, 32'hCAFEF00D);

        send(S_MWR, 32'h10, 32'h11223344, 1'b0);
        send(S_MWR, 32'h12, 32'h000000AA, 1'b1);
        send(S_MRD, 32'h10, 32'h0, 1'b0);
        check_vec("memrd_word", d_rd, 32'h11AA3344);
        send(S_MRD, 32'h13, 32'h0, 1'b1);
        check_vec("memrd_byte", d_rd, 32'h00000011);
        send(S_MRD, 32'h13, 32'h0, 1'b0);
        check_vec("memrd_word_unaligned", d_rd, 32'h11AA3344);

        send(S_MWR, 32'h400, 32'hDEADBEEF, 1'b0);
        check_vec("oor_wr_err", 32'(err_seen), 32'd1);
        send(S_MRD, 32'h0, 32'h0, 1'b0);
        check_vec("oor_wr_no_alias", d_rd, 32'h0);
        send(S_RRD, 32'd5, 32'h0, 1'b0);
        send(S_MRD, 32'h400, 32'h0, 1'b0);
        check_vec("oor_rd_err", 32'(err_seen), 32'd1);
        check_vec("oor_rd_data", d_rd, 32'h0);

        drive(S_RRD, 32'd5, 32'h0, 1'b0);
        @(negedge clk);
        drive(S_MWR, 32'h20, 32'h55, 1'b0);
        @(negedge clk);
        drive(7'b0, 32'h0, 32'h0, 1'b0);
        check_vec("drop_err", 32'(cmd_err), 32'd1);
        check_vec("drop_last_cmd", 32'(last_cmd), 32'd3);
        wait_idle();
        check_vec("drop_rd_ok", d_rd, 32'hCAFEF00D);
        send(S_MRD, 32'h20, 32'h0, 1'b0);
        check_vec("drop_no_write", d_rd, 32'h0);
        send(S_RRD, 32'd5, 32'h0, 1'b0);

        send(S_RESUME, 32'h0, 32'h0, 1'b0);
        check_vec("resume_last_cmd", 32'(last_cmd), 32'd2);
        check_vec("resume_paused_busy", 32'(paused_first), 32'd0);
        check_vec("resume_pc_first", pc_first, 32'd44);
        check_vec("resume_pc_after", pc, 32'd108);

        send(S_MRD, 32'h10, 32'h0, 1'b0);
        check_vec("run_memrd_err", 32'(err_seen), 32'd1);
        check_vec("run_memrd_last_cmd", 32'(last_cmd), 32'd5);
        check_vec("run_memrd_busy_len", 32'(busy_len), 32'd16);
        check_vec("run_memrd_d_rd", d_rd, 32'hCAFEF00D);

        send(S_RESET, 32'h0, 32'h0, 1'b0);
        check_vec("reset_pc_first", pc_first, 32'd0);
        check_vec("reset_last_cmd", 32'(last_cmd), 32'd7);
        check_vec("reset_pc_after", pc, 32'd64);

        send(S_PAUSE | S_RRD, 32'd9, 32'h0, 1'b0);
        check_vec("prio_last_cmd", 32'(last_cmd), 32'd1);
        check_vec("prio_paused", 32'(paused), 32'd1);
        check_vec("prio_d_rd", d_rd, 32'hCAFEF00D);
        send(S_RRD, 32'd9, 32'h0, 1'b0);
        check_vec("retain_reg", d_rd, 32'h12345678);
        send(S_MRD, 32'h10, 32'h0, 1'b0);
        check_vec("retain_mem", d_rd, 32'h11AA3344);

        drive(S_MWR, 32'h30, 32'hDEADBEEF, 1'b0);
        @(negedge clk);
        drive(7'b0, 32'h0, 32'h0, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_vec("midrst_busy", 32'(mcu_busy), 32'd0);
        check_vec("midrst_last_cmd", 32'(last_cmd), 32'd0);
        check_vec("midrst_d_rd", d_rd, 32'h0);
        repeat (255) @(negedge clk);
        check_vec("pc_top", pc, 32'd1020);
        @(negedge clk);
        check_vec("pc_wrap", pc, 32'd0);
        send(S_PAUSE, 32'h0, 32'h0, 1'b0);
        send(S_MRD, 32'h30, 32'h0, 1'b0);
        check_vec("midrst_mem", d_rd, 32'h0);
        send(S_MRD, 32'h10, 32'h0, 1'b0);
        check_vec("rst_clears_mem", d_rd, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
